// File: rtl/tcb_lib_memory.sv
// TCB subordinate scratch RAM: byte-enabled array, optional wait-state FSM, DLY-stage response pipe.
// Latency: response DLY cycles after each transfer (combinational when DLY = 0), one per cycle.
// Backpressure: rdy high whenever out of reset (WAIT = 0), else raised after WAIT cycles of held vld.
module tcb_lib_memory #(
    parameter  int unsigned ABW  = 32,
    parameter  int unsigned DBW  = 32,
    parameter  int unsigned SLW  = 8,
    parameter  int unsigned SIZ  = 4096,
    parameter  int unsigned DLY  = 1,
    parameter  int unsigned WAIT = 0,
    localparam int unsigned BEW  = DBW / SLW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vld,
    output logic           rdy,
    input  logic           req_wen,
    input  logic [ABW-1:0] req_adr,
    input  logic [BEW-1:0] req_ben,
    input  logic [DBW-1:0] req_wdt,
    output logic           rsp_vld,
    output logic [DBW-1:0] rsp_rdt,
    output logic           rsp_sts
);

    localparam int unsigned   OFS = $clog2(BEW);
    localparam int unsigned   DEP = SIZ / BEW;
    localparam int unsigned   IXW = (DEP > 1) ? $clog2(DEP) : 1;
    // one extra bit so SIZ == 2**ABW still compares correctly
    localparam logic [ABW:0]  LIM = (ABW+1)'(SIZ);

    // one pipeline slot: ena marks a transfer, rdt is already masked
    typedef struct packed {
        logic           ena;
        logic           sts;
        logic [DBW-1:0] rdt;
    } rsp_t;

    logic           trn;
    logic           in_rng;
    logic [IXW-1:0] idx;
    logic [DBW-1:0] rdt0;
    rsp_t           stg0;
    rsp_t           rsp_out;

    logic [DBW-1:0] mem_q [DEP];

    assign trn    = vld & rdy;
    assign in_rng = {1'b0, req_adr} < LIM;
    assign idx    = IXW'(req_adr >> OFS);

    // asynchronous read, masked by byte enables; writes, misses and idle cycles give zero
    always_comb begin
        rdt0 = '0;
        if (trn && !req_wen && in_rng) begin
            for (int b = 0; b < BEW; b++) begin
                if (req_ben[b]) begin
                    rdt0[b*SLW +: SLW] = mem_q[idx][b*SLW +: SLW];
                end
            end
        end
    end

    assign stg0 = {trn, trn & ~in_rng, rdt0};

    // byte-enabled write; array is deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (trn && req_wen && in_rng) begin
            for (int b = 0; b < BEW; b++) begin
                if (req_ben[b]) begin
                    mem_q[idx][b*SLW +: SLW] <= req_wdt[b*SLW +: SLW];
                end
            end
        end
    end

    generate
        if (DLY == 0) begin : g_comb
            assign rsp_out = stg0;
        end else begin : g_pipe
            rsp_t stg_q [DLY];

            // shift register of responses; reset drops anything in flight
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DLY; i++) begin
                        stg_q[i] <= '0;
                    end
                end else begin
                    stg_q[0] <= stg0;
                    for (int i = 1; i < DLY; i++) begin
                        stg_q[i] <= stg_q[i-1];
                    end
                end
            end

            assign rsp_out = stg_q[DLY-1];
        end
    endgenerate

    assign rsp_vld = rsp_out.ena;
    assign rsp_sts = rsp_out.sts;
    assign rsp_rdt = rsp_out.rdt;

    generate
        if (WAIT == 0) begin : g_nowait
            assign rdy = rst;
        end else begin : g_wait
            localparam int unsigned CW = $clog2(WAIT + 1);

            typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

            state_t        state_q;
            logic [CW-1:0] cnt_q;
            logic          rdy_q;

            // wait-state sequencer: rdy is raised in the (WAIT+1)-th cycle of held vld.
            // After a transfer it passes through IDLE, which restarts counting at cnt = 1
            // on the next held vld, so every transfer costs exactly WAIT+1 cycles.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    rdy_q   <= 1'b0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (vld) begin
                                if (WAIT == 1) begin
                                    state_q <= ST_READY;
                                    cnt_q   <= '0;
                                    rdy_q   <= 1'b1;
                                end else begin
                                    state_q <= ST_WAIT;
                                    cnt_q   <= CW'(1);
                                end
                            end
                        end
                        ST_WAIT: begin
                            if (!vld) begin
                                state_q <= ST_IDLE;
                                cnt_q   <= '0;
                            end else if (cnt_q + CW'(1) == CW'(WAIT)) begin
                                state_q <= ST_READY;
                                cnt_q   <= '0;
                                rdy_q   <= 1'b1;
                            end else begin
                                cnt_q   <= cnt_q + CW'(1);
                            end
                        end
                        ST_READY: begin
                            if (vld) begin
                                state_q <= ST_IDLE;
                                rdy_q   <= 1'b0;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            rdy_q   <= 1'b0;
                        end
                    endcase
                end
            end

            assign rdy = rdy_q;
        end
    endgenerate

endmodule

// File: tb/tb_tcb_lib_memory.sv
// Bench for tcb_lib_memory: four instances (DLY 1/2/0 sharing stimulus, DLY 3 with WAIT 2).
// Scoreboard queues hold expected responses with their due cycle.
// Outputs are sampled on the falling edge.
module tb_tcb_lib_memory;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // shared stimulus for instances a (DLY1), b (DLY2), d (DLY0)
    logic        x_vld, x_wen;
    logic [31:0] x_adr, x_wdt;
    logic [3:0]  x_ben;
    // stimulus for instance c (DLY3, WAIT2)
    logic        c_vld, c_wen;
    logic [31:0] c_adr, c_wdt;
    logic [3:0]  c_ben;

    logic        a_rdy, b_rdy, c_rdy, d_rdy;
    logic        a_rsp_vld, b_rsp_vld, c_rsp_vld, d_rsp_vld;
    logic        a_rsp_sts, b_rsp_sts, c_rsp_sts, d_rsp_sts;
    logic [31:0] a_rsp_rdt, b_rsp_rdt, c_rsp_rdt, d_rsp_rdt;

    tcb_lib_memory #(.SIZ(1024), .DLY(1), .WAIT(0)) u_a (
        .clk(clk), .rst(rst), .vld(x_vld), .rdy(a_rdy), .req_wen(x_wen), .req_adr(x_adr),
        .req_ben(x_ben), .req_wdt(x_wdt), .rsp_vld(a_rsp_vld), .rsp_rdt(a_rsp_rdt), .rsp_sts(a_rsp_sts));
    tcb_lib_memory #(.SIZ(1024), .DLY(2), .WAIT(0)) u_b (
        .clk(clk), .rst(rst), .vld(x_vld), .rdy(b_rdy), .req_wen(x_wen), .req_adr(x_adr),
        .req_ben(x_ben), .req_wdt(x_wdt), .rsp_vld(b_rsp_vld), .rsp_rdt(b_rsp_rdt), .rsp_sts(b_rsp_sts));
    tcb_lib_memory #(.SIZ(1024), .DLY(0), .WAIT(0)) u_d (
        .clk(clk), .rst(rst), .vld(x_vld), .rdy(d_rdy), .req_wen(x_wen), .req_adr(x_adr),
        .req_ben(x_ben), .req_wdt(x_wdt), .rsp_vld(d_rsp_vld), .rsp_rdt(d_rsp_rdt), .rsp_sts(d_rsp_sts));
    tcb_lib_memory #(.SIZ(1024), .DLY(3), .WAIT(2)) u_c (
        .clk(clk), .rst(rst), .vld(c_vld), .rdy(c_rdy), .req_wen(c_wen), .req_adr(c_adr),
        .req_ben(c_ben), .req_wdt(c_wdt), .rsp_vld(c_rsp_vld), .rsp_rdt(c_rsp_rdt), .rsp_sts(c_rsp_sts));

    typedef struct {
        logic [31:0] rdt;
        logic        sts;
        int          due;
    } exp_t;

    exp_t        sb [4][$];
    logic [31:0] mem [2][256];
    int          checks = 0;
    int          errors = 0;
    int          c_trn_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t predict(input int m, input logic wen, input logic [31:0] adr,
                                     input logic [3:0] ben);
        exp_t        e;
        logic [31:0] w;
        e.rdt = 32'h0;
        e.sts = (adr >= 32'd1024);
        e.due = 0;
        if (!wen && !e.sts) begin
            w = mem[m][adr[9:2]];
            for (int b = 0; b < 4; b++)
                if (ben[b]) e.rdt[8*b +: 8] = w[8*b +: 8];
        end
        return e;
    endfunction

    task automatic mwrite(input int m, input logic [31:0] adr, input logic [3:0] ben,
                          input logic [31:0] wdt);
        if (adr < 32'd1024)
            for (int b = 0; b < 4; b++)
                if (ben[b]) mem[m][adr[9:2]][8*b +: 8] = wdt[8*b +: 8];
    endtask

    task automatic mon(input int k, input string nm, input logic v, input logic [31:0] d,
                       input logic s);
        exp_t e;
        if (v) begin
            if (sb[k].size() == 0) begin
                chk({nm, "_spurious_rsp"}, v, 1'b0);
            end else begin
                e = sb[k].pop_front();
                chk({nm, "_rsp_cycle"}, cyc, e.due);
                chk({nm, "_rsp_rdt"}, d, e.rdt);
                chk({nm, "_rsp_sts"}, s, e.sts);
            end
        end else begin
            chk({nm, "_idle_rdt"}, d, 32'h0);
            if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
                chk({nm, "_rsp_missing"}, v, 1'b1);
                void'(sb[k].pop_front());
            end
        end
    endtask

    // scoreboard: push expectations on every transfer, then compare outputs
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int k = 0; k < 4; k++) sb[k].delete();
            chk("rst_rdy", {a_rdy, b_rdy, c_rdy, d_rdy}, 4'h0);
            chk("rst_rsp_vld", {a_rsp_vld, b_rsp_vld, c_rsp_vld, d_rsp_vld}, 4'h0);
            chk("rst_rsp_sts", {a_rsp_sts, b_rsp_sts, c_rsp_sts, d_rsp_sts}, 4'h0);
            chk("rst_rsp_rdt", a_rsp_rdt | b_rsp_rdt | c_rsp_rdt | d_rsp_rdt, 32'h0);
        end else begin
            e = predict(0, x_wen, x_adr, x_ben);
            if (x_vld & a_rdy) begin e.due = cyc + 1; sb[0].push_back(e); end
            if (x_vld & b_rdy) begin e.due = cyc + 2; sb[1].push_back(e); end
            if (x_vld & d_rdy) begin e.due = cyc;     sb[2].push_back(e); end
            if (x_vld & a_rdy & x_wen) mwrite(0, x_adr, x_ben, x_wdt);
            e = predict(1, c_wen, c_adr, c_ben);
            if (c_vld & c_rdy) begin
                e.due = cyc + 3;
                sb[3].push_back(e);
                c_trn_cnt++;
                if (c_wen) mwrite(1, c_adr, c_ben, c_wdt);
            end
            mon(0, "a", a_rsp_vld, a_rsp_rdt, a_rsp_sts);
            mon(1, "b", b_rsp_vld, b_rsp_rdt, b_rsp_sts);
            mon(2, "d", d_rsp_vld, d_rsp_rdt, d_rsp_sts);
            mon(3, "c", c_rsp_vld, c_rsp_rdt, c_rsp_sts);
        end
    end

    // one request per cycle on the WAIT=0 instances; vld stays high until x_idle
    task automatic x_req(input logic wen, input logic [31:0] adr, input logic [3:0] ben,
                         input logic [31:0] wdt);
        x_vld = 1'b1; x_wen = wen; x_adr = adr; x_ben = ben; x_wdt = wdt;
        @(posedge clk); #1;
    endtask

    task automatic x_idle();
        x_vld = 1'b0; x_wen = 1'b0;
    endtask

    // hold a request on instance c until it is accepted; reports cycles spent
    task automatic c_xfer(input logic wen, input logic [31:0] adr, input logic [3:0] ben,
                          input logic [31:0] wdt, output int ncyc);
        logic got;
        got  = 1'b0;
        ncyc = 0;
        c_vld = 1'b1; c_wen = wen; c_adr = adr; c_ben = ben; c_wdt = wdt;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = c_rdy;
            ncyc++;
            @(posedge clk); #1;
        end
        c_vld = 1'b0;
        chk("c_xfer_accepted", got, 1'b1);
    endtask

    initial begin
        int n0;
        int ncyc;
        int w;
        rst = 1'b0;
        x_vld = 1'b0; x_wen = 1'b0; x_adr = '0; x_ben = '0; x_wdt = '0;
        c_vld = 1'b0; c_wen = 1'b0; c_adr = '0; c_ben = '0; c_wdt = '0;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 256; i++) mem[m][i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // full-word write then read back
        x_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        x_req(1'b0, 32'h10, 4'hF, 32'h0);
        x_idle(); repeat (3) @(posedge clk); #1;

        // partial write and masked / unaligned reads
        x_req(1'b1, 32'h10, 4'b0100, 32'h00AA0000);
        x_req(1'b0, 32'h10, 4'hF, 32'h0);
        x_req(1'b0, 32'h10, 4'b0011, 32'h0);
        x_req(1'b0, 32'h12, 4'hF, 32'h0);
        x_idle(); repeat (3) @(posedge clk); #1;

        // range boundary at SIZ = 1024
        x_req(1'b1, 32'h3FC, 4'hF, 32'hCAFEF00D);
        x_req(1'b1, 32'h400, 4'hF, 32'h12345678);
        x_req(1'b0, 32'h400, 4'hF, 32'h0);
        x_req(1'b0, 32'h3FC, 4'hF, 32'h0);
        x_req(1'b0, 32'hFFFF_FFF0, 4'hF, 32'h0);
        x_idle(); repeat (3) @(posedge clk); #1;

        // back-to-back write/read pairs, consecutive responses
        x_req(1'b1, 32'h20, 4'hF, 32'h11111111);
        x_req(1'b0, 32'h20, 4'hF, 32'h0);
        x_req(1'b1, 32'h20, 4'hF, 32'h22222222);
        x_req(1'b0, 32'h20, 4'hF, 32'h0);
        x_idle(); repeat (4) @(posedge clk); #1;

        // random mix over a small window straddling the range limit
        for (int i = 0; i < 8; i++) x_req(1'b1, 32'h100 + 4*i, 4'hF, $urandom);
        for (int i = 0; i < 24; i++) begin
            w = $urandom_range(0, 15);
            if (w < 8) x_req(1'($urandom_range(0, 1)), 32'h100 + 4*w + $urandom_range(0, 3),
                             4'($urandom_range(0, 15)), $urandom);
            else       x_req(1'($urandom_range(0, 1)), 32'h400 + 4*(w-8),
                             4'($urandom_range(0, 15)), $urandom);
        end
        x_idle(); repeat (4) @(posedge clk); #1;

        // wait states: three held requests, rdy on cycles 3, 6, 9
        n0 = c_trn_cnt;
        c_vld = 1'b1; c_wen = 1'b1; c_adr = 32'h200; c_ben = 4'hF; c_wdt = 32'hA5A5A5A5;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("c_rdy_seq", c_rdy, (k % 3) == 0);
            @(posedge clk); #1;
            if (k == 3) begin c_adr = 32'h204; c_wdt = 32'h5A5A5A5A; end
            if (k == 6) begin c_wen = 1'b0; c_adr = 32'h200; end
            if (k == 9) c_vld = 1'b0;
        end
        chk("c_trn_count", c_trn_cnt - n0, 3);
        repeat (5) @(posedge clk); #1;

        // vld dropped during the wait phase: no transfer, FSM restarts cleanly
        n0 = c_trn_cnt;
        c_vld = 1'b1; c_wen = 1'b0; c_adr = 32'h204; c_ben = 4'hF;
        @(posedge clk); #1;
        c_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("c_rdy_after_drop", c_rdy, 1'b0);
        end
        @(posedge clk); #1;
        chk("c_no_trn_after_drop", c_trn_cnt - n0, 0);
        c_xfer(1'b0, 32'h204, 4'hF, 32'h0, ncyc);
        chk("c_wait_cycles", ncyc, 3);
        repeat (5) @(posedge clk); #1;

        // reset one cycle after a read transfer discards the in-flight response
        c_xfer(1'b0, 32'h200, 4'hF, 32'h0, ncyc);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("c_rst_async_vld", c_rsp_vld, 1'b0);
        chk("c_rst_async_rdy", c_rdy, 1'b0);
        chk("c_rst_async_rdt", c_rsp_rdt, 32'h0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) @(posedge clk); #1;
        c_xfer(1'b0, 32'h200, 4'hF, 32'h0, ncyc);
        x_req(1'b0, 32'h10, 4'hF, 32'h0);
        x_idle();
        repeat (6) @(posedge clk); #1;

        chk("drain", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
